result_display: RTL

Sequential binary-to-decimal display back end for the calculator. It takes the 16-bit `result` word produced by the calculator FSM and converts it to five BCD digits plus a sign, using an iterative double-dabble shift, one bit per clock. It then drives a time-multiplexed six-digit seven-segment display with leading-zero blanking and a minus sign. It sits directly downstream of the calculator's `result` output. Where the keypad side encodes decimal presses into binary, this block decodes binary back to decimal.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/bin2bcd_dd.sv | 101 ++++++++++
 rtl/result_display.sv | 95 +++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants for the calculator display back end
package calc_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } conv_state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_DIGITS = 5;

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles never occur and render blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - iterative double-dabble converter, one result bit per clock
module bin2bcd_dd
    import calc_pkg::*;
#(
    parameter int SIGNED_MODE = 1
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [15:0] result,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        negative
);

    conv_state_t r_state;
    conv_state_t w_state_next;

    logic [19:0] r_shift;
    logic [15:0] r_mag;
    logic [3:0]  r_cnt;
    logic        r_neg;
    logic [19:0] r_bcd;
    logic        r_negative;
    logic        r_done;

    logic        w_accept;
    logic        w_sign;
    logic [15:0] w_mag;
    logic [19:0] w_adj;
    logic [19:0] w_shifted;

    assign w_accept = (r_state == ST_IDLE) && load;
    assign w_sign   = (SIGNED_MODE != 0) && result[15];
    // Negating 16'h8000 yields 16'h8000, read back as unsigned 32768.
    assign w_mag    = w_sign ? (~result + 16'd1) : result;

    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_shift[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_shift[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = 20'({w_adj, r_mag[15]});

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (load) w_state_next = ST_CONVERT;
            ST_CONVERT: if (r_cnt == 4'd15) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_shift    <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_bcd      <= '0;
            r_negative <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift <= '0;
                r_mag   <= w_mag;
                r_cnt   <= '0;
                r_neg   <= w_sign;
            end else if (r_state == ST_CONVERT) begin
                r_shift <= w_shifted;
                r_mag   <= {r_mag[14:0], 1'b0};
                r_cnt   <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_bcd      <= w_shifted;
                    r_negative <= r_neg;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == ST_CONVERT);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign negative = r_negative;

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - binary result to multiplexed six-digit seven-segment display
module result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [15:0]           result,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [19:0]           bcd,
    output logic                  negative,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    logic [19:0] w_bcd;
    logic        w_negative;

    bin2bcd_dd #(
        .SIGNED_MODE(SIGNED_MODE)
    ) u_conv (
        .clk      (clk),
        .clear_n  (clear_n),
        .result   (result),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .bcd      (w_bcd),
        .negative (w_negative)
    );

    logic [15:0]           r_refresh;
    logic [2:0]            r_scan;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic                  w_wrap;
    logic [2:0]            w_scan_next;
    logic [2:0]            w_ms;
    logic [23:0]           w_digits;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_wrap      = (r_refresh == 16'(REFRESH_DIV - 1));
    assign w_scan_next = (r_scan == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_scan + 3'd1;
    assign w_digits    = {4'h0, w_bcd};

    // Ascending scan so the highest nonzero digit wins.
    always_comb begin
        w_ms = 3'd0;
        for (int i = 1; i < BCD_DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_ms = 3'(i);
            end
        end
    end

    always_comb begin
        w_seg_next = SEG_BLANK;
        if (w_scan_next <= w_ms) begin
            w_seg_next = seg_digit(w_digits[{w_scan_next, 2'b00} +: 4]);
        end else if (w_negative && (w_scan_next == w_ms + 3'd1)) begin
            w_seg_next = SEG_MINUS;
        end
    end

    assign w_an_next = ~(NUM_DIGITS'(1) << w_scan_next);

    // an/seg are latched only on a scan advance, so new content appears at the next digit step.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_refresh <= '0;
            r_scan    <= '0;
            r_an      <= 6'b111110;
            r_seg     <= 7'b1000000;
        end else if (w_wrap) begin
            r_refresh <= '0;
            r_scan    <= w_scan_next;
            r_an      <= w_an_next;
            r_seg     <= w_seg_next;
        end else begin
            r_refresh <= r_refresh + 16'd1;
        end
    end

    assign bcd      = w_bcd;
    assign negative = w_negative;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule
